// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for truth_table_scanner and its settle timer.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_IN_DEF = 2;
  localparam int NUM_VEC  = 2 ** N_IN_DEF;
  localparam int SETTLE_W = 4;

  // Reload value for the settle counter: WAIT lasts exactly 'settle' cycles.
  function automatic logic [SETTLE_W-1:0] settle_load(input int settle);
    return SETTLE_W'(settle - 1);
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Down-counter that loads SETTLE-1 and reports expiry when it has counted to zero.
module settle_timer
  import tts_pkg::*;
#(
  parameter logic [SETTLE_W-1:0] LOAD_VAL = 4'd0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [SETTLE_W-1:0] cnt;

  // Count register: load wins over decrement, and the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {SETTLE_W{1'b0}};
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != {SETTLE_W{1'b0}})) begin
      cnt <= cnt - {{(SETTLE_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign expired = (cnt == {SETTLE_W{1'b0}});

endmodule

// File: rtl/truth_table_scanner.sv
// Clocked exhaustive sweep of a two-implementation logic function, capturing both truth tables.
// Optional: define ABORT_ON_MISMATCH_EN to stop the sweep at the first disagreeing vector.
module truth_table_scanner
  import tts_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [N_IN-1:0]         x_out,
  input  logic                    res_a,
  input  logic                    res_b,
  output logic                    busy,
  output logic                    done,
  output logic [(2**N_IN)-1:0]    table_a,
  output logic [(2**N_IN)-1:0]    table_b,
  output logic [N_IN:0]           mismatch_cnt,
  output logic                    equal
);

  localparam int VEC_CNT = 2 ** N_IN;
  localparam int CW      = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(VEC_CNT - 1);
  localparam logic [N_IN-1:0] ONE_IDX  = N_IN'(1);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic            tmr_load;
  logic            tmr_en;
  logic            tmr_expired;
  logic            diff;
  logic            last_vec;
  logic            stop;
  logic [CW-1:0]   cnt_next;

  settle_timer #(
    .LOAD_VAL (settle_load(SETTLE))
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  assign diff     = res_a ^ res_b;
  assign last_vec = (idx == LAST_IDX);
  assign cnt_next = mismatch_cnt + CW'(diff);

`ifdef ABORT_ON_MISMATCH_EN
  assign stop = last_vec | diff;
`else
  assign stop = last_vec;
`endif

  // Settle timer is armed whenever a new vector is launched and counts only in WAIT.
  always_comb begin
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state)
      IDLE:    tmr_load = start;
      WAIT:    tmr_en   = 1'b1;
      SAMPLE:  tmr_load = ~stop;
      default: begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
      end
    endcase
  end

  // Sweep FSM with registered stimulus, status and captured results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= {N_IN{1'b0}};
      x_out        <= {N_IN{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      table_a      <= {VEC_CNT{1'b0}};
      table_b      <= {VEC_CNT{1'b0}};
      mismatch_cnt <= {CW{1'b0}};
      equal        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            table_a      <= {VEC_CNT{1'b0}};
            table_b      <= {VEC_CNT{1'b0}};
            mismatch_cnt <= {CW{1'b0}};
            equal        <= 1'b1;
            idx          <= {N_IN{1'b0}};
            x_out        <= {N_IN{1'b0}};
            busy         <= 1'b1;
            state        <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (tmr_expired) begin
            state <= SAMPLE;
          end else begin
            state <= WAIT;
          end
        end
        SAMPLE: begin
          table_a[idx] <= res_a;
          table_b[idx] <= res_b;
          mismatch_cnt <= cnt_next;
          equal        <= (cnt_next == {CW{1'b0}});
          // x_out only moves here, so downstream inputs stay stable across WAIT and SAMPLE.
          if (stop) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx   <= idx + ONE_IDX;
            x_out <= idx + ONE_IDX;
            state <= WAIT;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
